// File: rtl/regfile_pkg.sv
// Shared widths and constants for the RV32I integer register file.
// REGFILE_WB_BYPASS_EN (when defined) enables same-cycle WB->ID forwarding in the read ports.
package regfile_pkg;
  localparam int RF_DATA_W  = 32;
  localparam int RF_ADDR_W  = 5;
  localparam int RF_NREG    = 32;
  localparam int NUM_RPORTS = 2;

  localparam logic [RF_DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic [RF_ADDR_W-1:0] NOP_REG_ADDR = '0;
endpackage

// File: rtl/regfile_rport.sv
// One combinational read port: reset / enable / x0 / bypass / array priority mux.
// Bypass from the write port is compiled in only with REGFILE_WB_BYPASS_EN.
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREG   = RF_NREG
) (
  input  logic                        rst_i,
  input  logic [NREG-1:0][DATA_W-1:0] regs_i,
  input  logic                        we_i,
  input  logic [ADDR_W-1:0]           waddr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic                        re_i,
  input  logic [ADDR_W-1:0]           raddr_i,
  output logic [DATA_W-1:0]           rdata_o
);

`ifndef REGFILE_WB_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{we_i, waddr_i, wdata_i};
`endif

  // Enable is tested before the address so an X address on an idle port stays invisible.
  always_comb begin
    rdata_o = '0;
    if (rst_i && re_i) begin
      if (raddr_i != '0) begin
`ifdef REGFILE_WB_BYPASS_EN
        if (we_i && (waddr_i == raddr_i)) rdata_o = wdata_i;
        else                              rdata_o = regs_i[raddr_i];
`else
        rdata_o = regs_i[raddr_i];
`endif
      end
    end
  end

endmodule

// File: rtl/regfile.sv
// RV32I integer register file: x0 hardwired to zero, one write port, two read ports.
// Define REGFILE_WB_BYPASS_EN to forward the write-back value to the reads in the same cycle.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREG   = RF_NREG
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [NREG-1:0][DATA_W-1:0] regs_q;

  logic [NUM_RPORTS-1:0]             re;
  logic [NUM_RPORTS-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RPORTS-1:0][DATA_W-1:0] rdata;

  // Entry 0 is only ever reset, never written, so it reads as zero forever.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regs_q <= '0;
    end else if (we_i && (waddr_i != NOP_REG_ADDR)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign re    = {re2_i, re1_i};
  assign raddr = {raddr2_i, raddr1_i};

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    regfile_rport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREG   (NREG)
    ) u_rport (
      .rst_i   (rst_i),
      .regs_i  (regs_q),
      .we_i    (we_i),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .re_i    (re[p]),
      .raddr_i (raddr[p]),
      .rdata_o (rdata[p])
    );
  end

  assign rdata1_o = rdata[0];
  assign rdata2_o = rdata[1];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios then random traffic against an array model.
// Expectations follow REGFILE_WB_BYPASS_EN the same way the design does.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;

  logic [31:0] mdl [32];
  int n_cmp = 0;
  int n_mis = 0;

  regfile dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .re1_i    (re1),
    .raddr1_i (raddr1),
    .rdata1_o (rdata1),
    .re2_i    (re2),
    .raddr2_i (raddr2),
    .rdata2_o (rdata2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (!rst_n) return 32'h0;
    if (!re)    return 32'h0;
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return mdl[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ports(input string tag);
    chk({tag, "/p1"}, rdata1, exp_rd(re1, raddr1));
    chk({tag, "/p2"}, rdata2, exp_rd(re2, raddr2));
  endtask

  // Advance one rising edge, applying the architectural write rule to the model.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) foreach (mdl[i]) mdl[i] = 32'h0;
    else if (we && waddr != 5'd0) mdl[waddr] = wdata;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    cycle();
    we = 1'b0;
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = 32'h0;
    rst_n = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd5; raddr2 = 5'd5;

    // Writes attempted during reset must never land.
    #2;
    chk("rst_p1", rdata1, 32'h0);
    chk("rst_p2", rdata2, 32'h0);
    repeat (3) cycle();
    chk("rst_clk_p1", rdata1, 32'h0);
    chk("rst_clk_p2", rdata2, 32'h0);
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1;
    #1;
    chk("post_rst_x5", rdata1, 32'h0);

    // Basic write then read, and enable gating.
    wr(5'd3, 32'h1234_5678);
    raddr1 = 5'd3; re1 = 1'b1;
    #1 chk("basic_rd", rdata1, 32'h1234_5678);
    re1 = 1'b0;
    #1 chk("basic_re0", rdata1, 32'h0);
    re1 = 1'b1;

    // x0 stays zero.
    wr(5'd0, 32'hFFFF_FFFF);
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    chk("x0_p1", rdata1, 32'h0);
    chk("x0_p2", rdata2, 32'h0);

    // Same-cycle write/read of x7.
    wr(5'd7, 32'h0BAD_0007);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_0001;
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_pre_p1", rdata1, 32'hA5A5_0001);
    chk("byp_pre_p2", rdata2, 32'hA5A5_0001);
`else
    chk("byp_pre_p1", rdata1, 32'h0BAD_0007);
    chk("byp_pre_p2", rdata2, 32'h0BAD_0007);
`endif
    cycle();
    we = 1'b0;
    #1;
    chk("byp_post_p1", rdata1, 32'hA5A5_0001);
    chk("byp_post_p2", rdata2, 32'hA5A5_0001);

    // Back-to-back writes, then an asynchronous reset between edges.
    wr(5'd9, 32'd1);
    wr(5'd9, 32'd2);
    raddr1 = 5'd9;
    #1 chk("b2b_last", rdata1, 32'd2);
    #2 rst_n = 1'b0;
    foreach (mdl[i]) mdl[i] = 32'h0;
    #1 chk("async_rst_x9", rdata1, 32'h0);
    #1 rst_n = 1'b1;
    #1 chk("after_rst_x9", rdata1, 32'h0);

    // Dual-port independence with address swap.
    @(negedge clk);
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    raddr1 = 5'd1; raddr2 = 5'd2;
    #1;
    chk("dual_p1", rdata1, 32'h11);
    chk("dual_p2", rdata2, 32'h22);
    raddr1 = 5'd2; raddr2 = 5'd1;
    #1;
    chk("swap_p1", rdata1, 32'h22);
    chk("swap_p2", rdata2, 32'h11);

    // Random traffic; idle ports sometimes get an X address.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      we     = ($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 4) != 0);
      re2    = ($urandom_range(0, 4) != 0);
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      if (!re1 && $urandom_range(0, 1) == 1) raddr1 = 5'bx;
      if (!re2 && $urandom_range(0, 1) == 1) raddr2 = 5'bx;
      #1 chk_ports("rand");
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Integer register file for the 5-stage RV32I pipeline; terminal receiver of the MEM/WB write-back interface (`wb_we`, `wb_reg_waddr`, `wb_reg_wdata`).
- Holds x0..x31 and serves two combinational read ports to the ID stage.
- Provides same-cycle write-to-read forwarding so ID sees a value that WB is writing in that cycle (optional, see below).
- x0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits (matches `RegBus`).
- ADDR_W, 5, register address width (matches `RegAddrBus`).
- NREG, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  pipeline clock; all writes on rising edge.
- rst  input  1  asynchronous, active-low reset; clears all registers.
- we  input  1  write enable from MEM/WB (`wb_we`).
- waddr  input  ADDR_W  write address (`wb_reg_waddr`).
- wdata  input  DATA_W  write data (`wb_reg_wdata`).
- re1  input  1  read enable, port 1 (rs1).
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  DATA_W  read data, port 1.
- re2  input  1  read enable, port 2 (rs2).
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  DATA_W  read data, port 2.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-low.
- Reset:
  - While `rst`=0, every register is 0 regardless of `clk`.
  - `rdata1` and `rdata2` are 0 during reset.
  - Deasserting reset mid-operation discards nothing further; any write in flight at assertion is lost.
- Write:
  - On rising `clk` with `rst`=1, `we`=1 and `waddr`≠0: `reg[waddr]` ← `wdata`.
  - Writes to x0 are ignored; `reg[0]` stays 0 permanently.
  - `we`=0 leaves the array unchanged.
- Read (combinational, zero latency), evaluated per port in this priority:
  1. `rst`=0 → 0.
  2. `reN`=0 → 0.
  3. `raddrN`=0 → 0.
  4. Bypass hit (feature on) → `wdata`.
  5. Otherwise `reg[raddrN]`.
- Bypass hit: `we`=1, `waddr`=`raddrN`, `waddr`≠0.
- Both read ports are independent; both may target the same register, or the write address, in the same cycle.
- Write latency:
  - Without bypass, a write is visible on the read ports in the cycle after the edge.
  - With bypass, it is visible in the same cycle, and the following cycles read from the array.
- Back-to-back writes to the same address: the last edge wins. No write buffering and no stall output; the array accepts one write per cycle unconditionally.
- X-safety: when `reN`=0, `raddrN` may be X without affecting `rdataN`.

Optional Feature:
- Macro `REGFILE_WB_BYPASS_EN`.
- Defined: same-cycle write→read forwarding per read priority item 4, which removes the WB→ID hazard.
- Undefined: item 4 is removed; reads return array contents only. The hazard unit must then stall ID one cycle on a WB/ID address match.

Decomposition:
- `RegBus`, `RegAddrBus`, `RegNum` (32), `ZeroWord`, and `NOPRegAddr` (5'b0) come from `defines.v`; no new package is needed.
- One natural sub-module: `regfile_rport`, the per-port read mux (reset/enable/zero/bypass/array), instantiated twice.

Test Plan:
- Reset: hold `rst`=0, drive `we`=1, `waddr`=5, `wdata`=32'hDEAD_BEEF with clocks running → `rdata1`/`rdata2` stay 0 for `raddr`=5; after release, reading x5 returns 0.
- Basic write/read: write x3=32'h1234_5678 at edge N; read `raddr1`=3, `re1`=1 in cycle N+1 → 32'h1234_5678; with `re1`=0 → 0.
- x0 immutability: write x0=32'hFFFF_FFFF, then read `raddr1`=`raddr2`=0 → both ports 0.
- Bypass, same cycle: `we`=1, `waddr`=7, `wdata`=32'hA5A5_0001, `raddr1`=`raddr2`=7 in the same cycle.
  - Macro defined → both ports A5A5_0001 before the edge.
  - Macro undefined → both ports return the old x7 value, and A5A5_0001 after the edge.
- Back-to-back writes plus async reset: write x9=1, x9=2 on consecutive edges → read returns 2; assert `rst` mid-cycle (not on an edge) → x9 reads 0 immediately.
- Dual-port independence: x1=32'h11, x2=32'h22; `raddr1`=1, `raddr2`=2 → 0x11 and 0x22; swapping the addresses swaps the outputs in the same cycle.
